nibble_stream_demux: RTL and testbench
======================================

// Module: nibble_stream_demux
// PURPOSE
//  - Inverse of the lab's 2:1 nibble selector: receives one time-multiplexed W-bit stream (X beat, then Y beat) and rebuilds the X/Y pair.
//  - Presents each completed pair on parallel outputs with a valid/ready handshake.
//  - Sits between a serial nibble source (switch/FSM driver) and the LEDR/HEX display logic.
// PARAMETERS
//  - W        4    width of each data beat and of out_x/out_y
//  - CNT_W    8    width of drop_cnt (saturating)
// PORTS
//  - CLOCK_50   in   1      system clock, all logic on rising edge
//  - reset      in   1      synchronous, active-high reset
//  - in_data    in   W      stream beat
//  - in_valid   in   1      in_data valid this cycle
//  - in_first   in   1      qualifies beat as X (frame start); sampled only with in_valid
//  - in_ready   out  1      block accepts beat this cycle
//  - out_x      out  W      X nibble of current pair
//  - out_y      out  W      Y nibble of current pair
//  - out_valid  out  1      pair on out_x/out_y is valid
//  - out_ready  in   1      consumer accepts pair
//  - sel_y      out  1      1 = next accepted beat is loaded as Y (mirrors LEDR[9] select)
//  - drop_cnt   out  CNT_W  count of discarded partial frames
// BEHAVIOUR
//  - Beat accepted when in_valid & in_ready; pair handed off when out_valid & out_ready.
//  - FSM states: S_WAIT_X (0), S_WAIT_Y (1), S_FULL (2).
//  - Reset: state = S_WAIT_X; out_x = 0, out_y = 0, out_valid = 0, sel_y = 0, drop_cnt = 0. in_ready = 1 in the first cycle after reset.
//  - S_WAIT_X
//    - Accepted beat is loaded into the X register, whether in_first is 1 or 0 (the first beat after reset or a resync is X by definition).
//    - Next state S_WAIT_Y.
//  - S_WAIT_Y
//    - Accepted beat with in_first = 0: load into Y register, then out_valid = 1 the next cycle. Next state S_FULL.
//    - Accepted beat with in_first = 1: the held X is discarded and drop_cnt is incremented. The new beat is loaded as X; state stays S_WAIT_Y.
//  - S_FULL
//    - out_x/out_y are stable and out_valid = 1 until the handoff.
//    - in_ready = out_ready, so the next X can be accepted in the same cycle as the handoff.
//    - Handoff without an accepted beat: out_valid -> 0 next cycle; state -> S_WAIT_X.
//    - Handoff with an accepted beat: that beat is loaded as X regardless of in_first; state -> S_WAIT_Y.
//  - in_ready = 1 in S_WAIT_X and S_WAIT_Y. In S_FULL, in_ready = out_ready (combinational from out_ready only).
//  - sel_y = 1 exactly in S_WAIT_Y (registered state decode).
//  - Latency: Y beat accepted in cycle n -> out_valid = 1 in cycle n+1.
//  - Throughput: 1 pair per 2 cycles under continuous valid and ready.
//  - out_x/out_y update only when entering S_FULL; they hold their old values otherwise, including after a handoff.
//  - Reset asserted mid-frame or mid-pair: the partial X and the pending pair are lost. This is not counted in drop_cnt.
//  - drop_cnt saturates at 2^CNT_W-1 and does not wrap.
//  - in_first while in S_FULL: no drop, because the pair is already complete.
// CONFIGURATION
//  - Macro NIBBLE_STREAM_DEMUX_DROP_CNT_EN
//    - Defined: drop_cnt counts as described above.
//    - Undefined: the drop counter register is not built and drop_cnt is tied to 0.
//    - Both cases: the FSM still discards the partial X on in_first in S_WAIT_Y.
// TESTING
//  - Reset: assert reset 2 cycles -> out_valid = 0, out_x = 0, out_y = 0, sel_y = 0, drop_cnt = 0, in_ready = 1.
//  - Basic pair, out_ready = 1: beats 4'hA (first = 1), 4'h5 -> next cycle out_x = A, out_y = 5, out_valid = 1 for one cycle.
//  - Backpressure: out_ready = 0 after pair 3/C; offer 4'h7
//    - in_ready = 0, pair 3/C holds for 5 cycles.
//    - Raise out_ready -> 7 accepted in the handoff cycle, sel_y = 1 next cycle.
//  - Resync: beats 4'h1 (first = 1), 4'h2 (first = 1), 4'h9 -> out_x = 2, out_y = 9; drop_cnt = 1 (0 if macro undefined).
//  - Saturation (CNT_W = 2): 5 consecutive first-flagged beats after one X -> drop_cnt sticks at 3.
//  - Mid-frame reset: X = 4'hF accepted, reset for 1 cycle, then beat 4'h6 -> 6 is loaded as X (sel_y = 1), no out_valid.

Source files
------------

// File: rtl/nibble_stream_demux.sv
// nibble_stream_demux: rebuilds X/Y nibble pairs from one serial beat stream.
// Optional drop counter: define NIBBLE_STREAM_DEMUX_DROP_CNT_EN to build it.
module nibble_stream_demux #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_first,
  output logic             in_ready,
  output logic [W-1:0]     out_x,
  output logic [W-1:0]     out_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel_y,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    S_WAIT_X = 2'd0,
    S_WAIT_Y = 2'd1,
    S_FULL   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0] x_q;
  logic         acc;
  logic         ld_x;
  logic         ld_pair;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_WAIT_X;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_WAIT_X: if (acc) state_nxt = S_WAIT_Y;
      S_WAIT_Y: if (acc && !in_first) state_nxt = S_FULL;
      S_FULL: begin
        if (out_ready) state_nxt = acc ? S_WAIT_Y : S_WAIT_X;
      end
      default: state_nxt = S_WAIT_X;
    endcase
  end

  // Handshake outputs and datapath load strobes from state decode
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    sel_y     = 1'b0;
    acc       = 1'b0;
    ld_x      = 1'b0;
    ld_pair   = 1'b0;
    unique case (state)
      S_WAIT_X: begin
        acc  = in_valid;
        ld_x = acc;
      end
      S_WAIT_Y: begin
        sel_y   = 1'b1;
        acc     = in_valid;
        ld_x    = acc && in_first;
        ld_pair = acc && !in_first;
      end
      S_FULL: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        acc       = in_valid && out_ready;
        ld_x      = acc;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

  // X holding register for the frame in progress
  always_ff @(posedge CLOCK_50) begin
    if (reset)     x_q <= '0;
    else if (ld_x) x_q <= in_data;
  end

  // Output pair only changes when a pair completes
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      out_x <= '0;
      out_y <= '0;
    end else if (ld_pair) begin
      out_x <= x_q;
      out_y <= in_data;
    end
  end

`ifdef NIBBLE_STREAM_DEMUX_DROP_CNT_EN
  logic drop;
  assign drop = sel_y && acc && in_first;

  // Saturating count of partial frames abandoned by a resync
  always_ff @(posedge CLOCK_50) begin
    if (reset) drop_cnt <= '0;
    else if (drop && (drop_cnt != {CNT_W{1'b1}}))
      drop_cnt <= drop_cnt + 1'b1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_nibble_stream_demux.sv
// tb_nibble_stream_demux: directed beats, scoreboard queue of expected pairs.
module tb_nibble_stream_demux;

  localparam int W     = 4;
  localparam int CNT_W = 2;
`ifdef NIBBLE_STREAM_DEMUX_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_first;
  logic             in_ready;
  logic [W-1:0]     out_x;
  logic [W-1:0]     out_y;
  logic             out_valid;
  logic             out_ready;
  logic             sel_y;
  logic [CNT_W-1:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_stream_demux #(.W(W), .CNT_W(CNT_W)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_first (in_first),
    .in_ready (in_ready),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel_y    (sel_y),
    .drop_cnt (drop_cnt)
  );

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int dexp(int v);
    return CNT_EN ? v : 0;
  endfunction

  // Monitor: every handoff must match the oldest expected pair
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pair", {out_x, out_y}, 0);
      end else begin
        chk("pair", {out_x, out_y}, exp_q.pop_front());
      end
    end
  end

  task automatic beat(logic [W-1:0] d, logic f);
    int n;
    in_data  = d;
    in_first = f;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("beat_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  logic [W-1:0] tx[3] = '{4'h1, 4'h3, 4'h5};
  logic [W-1:0] ty[3] = '{4'h2, 4'h4, 4'h6};

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    idle(2);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_sel_y", sel_y, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post_rst_in_ready", in_ready, 1);

    // Basic pair
    out_ready = 1'b1;
    beat(4'hA, 1'b1);
    chk("sel_y_after_x", sel_y, 1);
    exp_q.push_back({4'hA, 4'h5});
    beat(4'h5, 1'b0);
    chk("basic_valid", out_valid, 1);
    chk("basic_sel_y", sel_y, 0);
    idle(1);
    chk("basic_valid_drop", out_valid, 0);
    chk("basic_hold_x", out_x, 4'hA);
    chk("basic_hold_y", out_y, 4'h5);

    // Back-to-back pairs under continuous ready
    for (int i = 0; i < 3; i++) begin
      beat(tx[i], 1'b1);
      exp_q.push_back({tx[i], ty[i]});
      beat(ty[i], 1'b0);
    end
    idle(1);

    // Backpressure
    out_ready = 1'b0;
    beat(4'h3, 1'b1);
    exp_q.push_back({4'h3, 4'hC});
    beat(4'hC, 1'b0);
    in_data  = 4'h7;
    in_first = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_pair", {out_x, out_y}, {4'h3, 4'hC});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    chk("bp_sel_y", sel_y, 1);
    chk("bp_valid_after", out_valid, 0);
    exp_q.push_back({4'h7, 4'h8});
    beat(4'h8, 1'b0);
    idle(1);

    // Resync drops the held X
    beat(4'h1, 1'b1);
    beat(4'h2, 1'b1);
    chk("resync_sel_y", sel_y, 1);
    chk("resync_drop", drop_cnt, dexp(1));
    exp_q.push_back({4'h2, 4'h9});
    beat(4'h9, 1'b0);
    idle(1);
    chk("resync_x", out_x, 4'h2);
    chk("resync_y", out_y, 4'h9);

    // First flag in S_FULL is not a drop
    out_ready = 1'b0;
    beat(4'hB, 1'b1);
    exp_q.push_back({4'hB, 4'hD});
    beat(4'hD, 1'b0);
    out_ready = 1'b1;
    exp_q.push_back({4'hE, 4'h4});
    beat(4'hE, 1'b1);
    beat(4'h4, 1'b0);
    idle(1);
    chk("full_first_nodrop", drop_cnt, dexp(1));

    // Saturation
    do_reset(1);
    chk("sat_rst", drop_cnt, 0);
    beat(4'hE, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      beat(W'(i), 1'b1);
      chk("sat_drop", drop_cnt, dexp(i > 3 ? 3 : i));
    end
    chk("sat_no_valid", out_valid, 0);

    // Mid-frame reset
    do_reset(1);
    beat(4'hF, 1'b1);
    do_reset(1);
    chk("mid_rst_sel_y", sel_y, 0);
    beat(4'h6, 1'b0);
    chk("mid_sel_y", sel_y, 1);
    chk("mid_valid", out_valid, 0);
    chk("mid_drop", drop_cnt, 0);
    idle(2);
    chk("mid_valid_later", out_valid, 0);
    exp_q.push_back({4'h6, 4'h3});
    beat(4'h3, 1'b0);
    idle(2);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
